// File: rtl/btn_evt_pkg.sv
// -----------------------------------------------------------------------------
// btn_evt_pkg
// Shared types and constants for the button event classifier.
//   state_e  : classifier FSM states
//   EV_*     : 2-bit event codes carried on ev_code
// -----------------------------------------------------------------------------
package btn_evt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        GAP,
        PRESS2,
        LONG_HOLD
    } state_e;

    localparam logic [1:0] EV_REPEAT = 2'b00;
    localparam logic [1:0] EV_SHORT  = 2'b01;
    localparam logic [1:0] EV_LONG   = 2'b10;
    localparam logic [1:0] EV_DOUBLE = 2'b11;

endpackage

// File: rtl/button_event_classifier_if.sv
// -----------------------------------------------------------------------------
// button_event_classifier_if
// Bundles the debouncer input pair and the classified event outputs.
//   db_level : debounced switch level
//   db_tick  : 1-cycle pulse on debounced rising edge (one cycle before db_level=1)
//   ev_valid : 1-cycle event strobe
//   ev_code  : event code, valid only with ev_valid
//   held     : high while a LONG press is still held
// Modports:
//   master : drives db_level/db_tick, observes the event outputs
//   slave  : the classifier itself
// -----------------------------------------------------------------------------
interface button_event_classifier_if;

    logic       db_level;
    logic       db_tick;
    logic       ev_valid;
    logic [1:0] ev_code;
    logic       held;

    modport master (
        output db_level, db_tick,
        input  ev_valid, ev_code, held
    );

    modport slave (
        input  db_level, db_tick,
        output ev_valid, ev_code, held
    );

endinterface

// File: rtl/press_timer.sv
// -----------------------------------------------------------------------------
// press_timer
// Cycle counter shared by all timed classifier states. The count is cleared by
// the owner and only advances while enabled, so it never runs free or wraps.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : force count to zero (wins over enable)
//   enable   : advance count by one this cycle
//   tc_val   : terminal value to compare against
//   tc       : high while count equals tc_val
// -----------------------------------------------------------------------------
module press_timer #(
    parameter int CW = 26
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          enable,
    input  logic [CW-1:0] tc_val,
    output logic          tc
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == tc_val);

endmodule

// File: rtl/button_event_classifier.sv
// -----------------------------------------------------------------------------
// button_event_classifier
// Classifies debounced button gestures as SHORT, LONG or DOUBLE and reports
// each as a registered one-cycle ev_valid strobe with ev_code.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : button_event_classifier_if.slave (db_level, db_tick in;
//              ev_valid, ev_code, held out)
// Parameters: LONG_CYC, DBL_CYC, REPEAT_CYC (cycles), CW (counter width).
// Optional feature: define BTN_REPEAT_EN to emit REPEAT events every
// REPEAT_CYC cycles while a LONG press stays held.
// -----------------------------------------------------------------------------
module button_event_classifier
    import btn_evt_pkg::*;
#(
    parameter int LONG_CYC   = 50_000_000,
    parameter int DBL_CYC    = 25_000_000,
    parameter int REPEAT_CYC = 10_000_000,
    parameter int CW         = 26
) (
    input  logic                       clk,
    input  logic                       rst,
    button_event_classifier_if.slave   bus
);

    state_e     state_q, state_d;
    logic       lvl_q;
    logic       ev_valid_q, ev_valid_d;
    logic [1:0] ev_code_q, ev_code_d;
    logic       held_q, held_d;

    logic          fall;
    logic          timer_clr;
    logic          timer_en;
    logic [CW-1:0] tc_val;
    logic          tc;

    assign fall = lvl_q & ~bus.db_level;

    press_timer #(.CW(CW)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clr),
        .enable (timer_en),
        .tc_val (tc_val),
        .tc     (tc)
    );

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        ev_valid_d = 1'b0;
        ev_code_d = EV_REPEAT;
        timer_en  = 1'b0;
        timer_clr = 1'b0;
        tc_val    = '0;

        unique case (state_q)
            IDLE: begin
                if (bus.db_tick) state_d = PRESS1;
            end
            PRESS1: begin
                timer_en = 1'b1;
                tc_val   = CW'(LONG_CYC - 1);
                // A release on the terminal cycle still counts as a short press.
                if (fall) begin
                    state_d = GAP;
                end else if (tc) begin
                    state_d    = LONG_HOLD;
                    ev_valid_d = 1'b1;
                    ev_code_d  = EV_LONG;
                end
            end
            GAP: begin
                timer_en = 1'b1;
                tc_val   = CW'(DBL_CYC - 1);
                // Second tick beats window expiry on the same cycle.
                if (bus.db_tick) begin
                    state_d = PRESS2;
                end else if (tc) begin
                    state_d    = IDLE;
                    ev_valid_d = 1'b1;
                    ev_code_d  = EV_SHORT;
                end
            end
            PRESS2: begin
                if (fall) begin
                    state_d    = IDLE;
                    ev_valid_d = 1'b1;
                    ev_code_d  = EV_DOUBLE;
                end
            end
            LONG_HOLD: begin
                tc_val = CW'(REPEAT_CYC - 1);
                if (fall) begin
                    state_d = IDLE;
                end else begin
`ifdef BTN_REPEAT_EN
                    timer_en = 1'b1;
                    if (tc) begin
                        ev_valid_d = 1'b1;
                        ev_code_d  = EV_REPEAT;
                        timer_clr  = 1'b1;  // restart the repeat period
                    end
`else
                    timer_en = 1'b0;        // counter parked; no repeats
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        // Each timed state measures from its own entry.
        if (state_d != state_q) timer_clr = 1'b1;

        held_d = (state_d == LONG_HOLD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            lvl_q      <= 1'b0;
            ev_valid_q <= 1'b0;
            ev_code_q  <= EV_REPEAT;
            held_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lvl_q      <= bus.db_level;
            ev_valid_q <= ev_valid_d;
            ev_code_q  <= ev_code_d;
            held_q     <= held_d;
        end
    end

    assign bus.ev_valid = ev_valid_q;
    assign bus.ev_code  = ev_code_q;
    assign bus.held     = held_q;

endmodule

// File: tb/tb_button_event_classifier.sv
// -----------------------------------------------------------------------------
// tb_button_event_classifier
// Self-checking bench for button_event_classifier (LONG_CYC=20, DBL_CYC=10,
// REPEAT_CYC=5). Gestures are planned up front as a per-cycle input schedule;
// the expected outputs for each gesture are derived from its press/release
// times. Directed gestures come first, then random ones, then reset cases.
// Honours BTN_REPEAT_EN when the design is built with it.
// -----------------------------------------------------------------------------
module tb_button_event_classifier;
    import btn_evt_pkg::*;

    localparam int LONG_CYC   = 20;
    localparam int DBL_CYC    = 10;
    localparam int REPEAT_CYC = 5;
    localparam int MAXC       = 4096;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    button_event_classifier_if bif ();

    button_event_classifier #(
        .LONG_CYC   (LONG_CYC),
        .DBL_CYC    (DBL_CYC),
        .REPEAT_CYC (REPEAT_CYC),
        .CW         (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Per-cycle schedule: inputs and expected outputs.
    logic       lvl_a  [MAXC];
    logic       tick_a [MAXC];
    logic       expv_a [MAXC];
    logic       exph_a [MAXC];
    logic [1:0] expc_a [MAXC];
    int         cur;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Plan one gesture starting at cycle cur. p1 = cycles held, g = cycles low
    // before the second press (0 = no second press), p2 = second press length,
    // idle = quiet cycles after the gesture completes.
    task automatic add_gesture(input int p1, input int g, input int p2, input int idle);
        int t, f, f2;
        t = cur;
        tick_a[t] = 1'b1;
        for (int i = 1; i <= p1; i++) lvl_a[t+i] = 1'b1;
        f = t + p1 + 1;                      // first low cycle (release)
        if (p1 >= LONG_CYC) begin
            for (int c = t + LONG_CYC + 1; c <= f; c++) exph_a[c] = 1'b1;
            expv_a[t+LONG_CYC+1] = 1'b1;
            expc_a[t+LONG_CYC+1] = EV_LONG;
`ifdef BTN_REPEAT_EN
            for (int c = t + LONG_CYC + 1 + REPEAT_CYC; c <= f; c += REPEAT_CYC) begin
                expv_a[c] = 1'b1;
                expc_a[c] = EV_REPEAT;
            end
`endif
            cur = f + 1 + idle;
        end else if (g == 0) begin
            expv_a[f+DBL_CYC+1] = 1'b1;
            expc_a[f+DBL_CYC+1] = EV_SHORT;
            cur = f + DBL_CYC + 1 + idle;
        end else begin
            tick_a[f+g-1] = 1'b1;            // tick precedes the level by one cycle
            for (int i = 0; i < p2; i++) lvl_a[f+g+i] = 1'b1;
            f2 = f + g + p2;
            expv_a[f2+1] = 1'b1;
            expc_a[f2+1] = EV_DOUBLE;
            cur = f2 + 1 + idle;
        end
    endtask

    task automatic step(input logic l, input logic t);
        @(posedge clk);
        #1;
        bif.db_level = l;
        bif.db_tick  = t;
        @(negedge clk);
    endtask

    task automatic quiet_after_reset(input string tag);
        // Level still high after reset, then released: nothing may be reported.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 35; i++) begin
            step(1'b0, 1'b0);
            check($sformatf("%s_valid@%0d", tag, i), {31'd0, bif.ev_valid}, 32'd0);
            check($sformatf("%s_held@%0d", tag, i), {31'd0, bif.held}, 32'd0);
        end
    endtask

    initial begin
        int kind, p1, g, p2, nrun;

        for (int c = 0; c < MAXC; c++) begin
            lvl_a[c] = 1'b0; tick_a[c] = 1'b0;
            expv_a[c] = 1'b0; exph_a[c] = 1'b0; expc_a[c] = EV_REPEAT;
        end

        // Directed gestures, then random ones.
        cur = 2;
        add_gesture(5, 0, 0, 20);            // SHORT at F+11
        add_gesture(30, 0, 0, 5);            // LONG at T+21, held to F
        add_gesture(3, 4, 3, 5);             // DOUBLE at F2+1
        add_gesture(3, DBL_CYC + 1, 2, 5);   // second tick on expiry cycle
        add_gesture(33, 0, 0, 5);            // LONG (+ REPEATs at T+26, T+31)
        while (cur < MAXC - 200) begin
            kind = int'($urandom_range(0, 2));
            p1 = int'($urandom_range(1, LONG_CYC - 2));
            g = 0;
            p2 = 0;
            if (kind == 1) begin
                // Avoid releases that coincide with a repeat boundary.
                do p1 = int'($urandom_range(LONG_CYC, LONG_CYC + 25));
                while (((p1 - (LONG_CYC - 1)) % REPEAT_CYC) == 0);
            end else if (kind == 2) begin
                g  = int'($urandom_range(2, DBL_CYC + 1));
                p2 = int'($urandom_range(1, 30));
            end
            add_gesture(p1, g, p2, int'($urandom_range(0, 8)));
        end
        nrun = cur + 40;

        // Reset state.
        rst = 1'b1;
        bif.db_level = 1'b0;
        bif.db_tick  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, bif.ev_valid}, 32'd0);
        check("rst_code",  {30'd0, bif.ev_code},  32'd0);
        check("rst_held",  {31'd0, bif.held},     32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Scheduled gestures.
        for (int c = 0; c < nrun; c++) begin
            step(lvl_a[c], tick_a[c]);
            check($sformatf("valid@%0d", c), {31'd0, bif.ev_valid}, {31'd0, expv_a[c]});
            check($sformatf("held@%0d", c),  {31'd0, bif.held},     {31'd0, exph_a[c]});
            if (expv_a[c])
                check($sformatf("code@%0d", c), {30'd0, bif.ev_code}, {30'd0, expc_a[c]});
        end

        // Reset during PRESS1 (8 cycles into the press).
        step(1'b0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
        rst = 1'b1;
        #1;
        check("rstp1_valid", {31'd0, bif.ev_valid}, 32'd0);
        check("rstp1_held",  {31'd0, bif.held},     32'd0);
        #2;
        rst = 1'b0;
        quiet_after_reset("rstp1");

        // Reset while a LONG press is held: held must drop at once.
        step(1'b0, 1'b1);
        for (int i = 0; i < LONG_CYC + 5; i++) step(1'b1, 1'b0);
        check("lh_held_before", {31'd0, bif.held}, 32'd1);
        rst = 1'b1;
        #1;
        check("rstlh_held",  {31'd0, bif.held},     32'd0);
        check("rstlh_valid", {31'd0, bif.ev_valid}, 32'd0);
        #2;
        rst = 1'b0;
        quiet_after_reset("rstlh");

        // Normal operation resumes: SHORT at F+11.
        step(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 15; i++) begin
            step(1'b0, 1'b0);
            check($sformatf("post_valid@%0d", i), {31'd0, bif.ev_valid}, {31'd0, (i == DBL_CYC + 1)});
            if (i == DBL_CYC + 1)
                check("post_code", {30'd0, bif.ev_code}, {30'd0, EV_SHORT});
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
